// File: rtl/intra4x4_mode_decide.sv
// Intra 4x4 mode decision: captures eight residual blocks, evaluates one mode SAD per cycle
// and reports the lowest-SAD enabled mode (ties resolved toward the lower mode index).
module intra4x4_mode_decide #(
   parameter int SAD_W  = 12,
   parameter int MODE_W = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [7:0]          mode_mask,
   input  logic [127:0]        vres,
   input  logic [127:0]        hres,
   input  logic [127:0]        vlres,
   input  logic [127:0]        vrres,
   input  logic [127:0]        hures,
   input  logic [127:0]        hdres,
   input  logic [127:0]        ddlres,
   input  logic [127:0]        ddrres,
   output logic                busy,
   output logic                done,
   output logic [MODE_W-1:0]   best_mode,
   output logic [SAD_W-1:0]    best_sad,
   output logic                none_valid
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EVAL = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [MODE_W-1:0] LAST_IDX = MODE_W'(7);

   logic [1:0]        state_q, state_d;
   logic [MODE_W-1:0] idx_q, idx_d;
   logic [7:0]        mask_q, mask_d;
   logic [127:0]      res_q [8];
   logic [127:0]      res_d [8];
   logic [SAD_W-1:0]  best_sad_r_q, best_sad_r_d;
   logic [MODE_W-1:0] best_mode_r_q, best_mode_r_d;
   logic              found_q, found_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [MODE_W-1:0] best_mode_q, best_mode_d;
   logic [SAD_W-1:0]  best_sad_q, best_sad_d;
   logic              none_valid_q, none_valid_d;

   logic [127:0]      cur_blk;
   logic [SAD_W-1:0]  lvl0 [16];
   logic [SAD_W-1:0]  lvl1 [8];
   logic [SAD_W-1:0]  lvl2 [4];
   logic [SAD_W-1:0]  lvl3 [2];
   logic [SAD_W-1:0]  sad_cur;
   logic              take_mode;

   // Magnitude of a two's complement byte; -128 maps to 128, hence 9 bits.
   function automatic logic [8:0] abs_mag(input logic [7:0] r);
      logic [8:0] m;
      if (r[7])
         m = 9'd256 - {1'b0, r};
      else
         m = {1'b0, r};
      return m;
   endfunction

   assign cur_blk = res_q[idx_q];

   always_comb begin
      for (int i = 0; i < 16; i++) begin
         lvl0[i] = {{(SAD_W-9){1'b0}}, abs_mag(cur_blk[8*i +: 8])};
      end
      for (int i = 0; i < 8; i++) begin
         lvl1[i] = lvl0[2*i] + lvl0[2*i+1];
      end
      for (int i = 0; i < 4; i++) begin
         lvl2[i] = lvl1[2*i] + lvl1[2*i+1];
      end
      for (int i = 0; i < 2; i++) begin
         lvl3[i] = lvl2[2*i] + lvl2[2*i+1];
      end
      sad_cur = lvl3[0] + lvl3[1];
   end

   assign take_mode = mask_q[idx_q] && (!found_q || (sad_cur < best_sad_r_q));

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      mask_d        = mask_q;
      res_d         = res_q;
      best_sad_r_d  = best_sad_r_q;
      best_mode_r_d = best_mode_r_q;
      found_d       = found_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      best_mode_d   = best_mode_q;
      best_sad_d    = best_sad_q;
      none_valid_d  = none_valid_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               res_d[0]      = vres;
               res_d[1]      = hres;
               res_d[2]      = vlres;
               res_d[3]      = vrres;
               res_d[4]      = hures;
               res_d[5]      = hdres;
               res_d[6]      = ddlres;
               res_d[7]      = ddrres;
               mask_d        = mode_mask;
               idx_d         = '0;
               best_sad_r_d  = '1;
               best_mode_r_d = '0;
               found_d       = 1'b0;
               busy_d        = 1'b1;
               state_d       = S_EVAL;
            end
         end
         S_EVAL: begin
            if (take_mode) begin
               best_sad_r_d  = sad_cur;
               best_mode_r_d = idx_q;
               found_d       = 1'b1;
            end
            if (idx_q == LAST_IDX)
               state_d = S_DONE;
            else
               idx_d = idx_q + MODE_W'(1);
         end
         S_DONE: begin
            // With no mode found the running best still holds mode 0 / all ones.
            busy_d       = 1'b0;
            done_d       = 1'b1;
            best_mode_d  = best_mode_r_q;
            best_sad_d   = best_sad_r_q;
            none_valid_d = !found_q;
            state_d      = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         idx_q         <= '0;
         mask_q        <= '0;
         for (int i = 0; i < 8; i++) begin
            res_q[i] <= '0;
         end
         best_sad_r_q  <= '0;
         best_mode_r_q <= '0;
         found_q       <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         best_mode_q   <= '0;
         best_sad_q    <= '0;
         none_valid_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         mask_q        <= mask_d;
         res_q         <= res_d;
         best_sad_r_q  <= best_sad_r_d;
         best_mode_r_q <= best_mode_r_d;
         found_q       <= found_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         best_mode_q   <= best_mode_d;
         best_sad_q    <= best_sad_d;
         none_valid_q  <= none_valid_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign best_mode  = best_mode_q;
   assign best_sad   = best_sad_q;
   assign none_valid = none_valid_q;

endmodule

// File: tb/tb_intra4x4_mode_decide.sv
// Self-checking bench for intra4x4_mode_decide: directed table, corner-case sequences and
// randomized decisions checked against a per-mode SAD / minimum-search reference model.
module tb_intra4x4_mode_decide;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [7:0]   mode_mask;
   logic [127:0] vres, hres, vlres, vrres, hures, hdres, ddlres, ddrres;
   logic         busy, done;
   logic [2:0]   best_mode;
   logic [11:0]  best_sad;
   logic         none_valid;

   int total = 0;
   int bad   = 0;

   logic [127:0] cur_blk [8];
   logic [2:0]   exp_mode;
   logic [11:0]  exp_sad;
   logic         exp_none;

   typedef struct {
      string       name;
      logic [7:0]  mask;
      logic [63:0] fill;
      logic [2:0]  mode;
      logic [11:0] sad;
      logic        none;
   } vec_t;

   vec_t vecs [8];

   intra4x4_mode_decide #(.SAD_W(12), .MODE_W(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .mode_mask  (mode_mask),
      .vres       (vres),
      .hres       (hres),
      .vlres      (vlres),
      .vrres      (vrres),
      .hures      (hures),
      .hdres      (hdres),
      .ddlres     (ddlres),
      .ddrres     (ddrres),
      .busy       (busy),
      .done       (done),
      .best_mode  (best_mode),
      .best_sad   (best_sad),
      .none_valid (none_valid)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic driveBlocks();
      vres   = cur_blk[0];
      hres   = cur_blk[1];
      vlres  = cur_blk[2];
      vrres  = cur_blk[3];
      hures  = cur_blk[4];
      hdres  = cur_blk[5];
      ddlres = cur_blk[6];
      ddrres = cur_blk[7];
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic scramblePorts();
      vres   = rand128();
      hres   = rand128();
      vlres  = rand128();
      vrres  = rand128();
      hures  = rand128();
      hdres  = rand128();
      ddlres = rand128();
      ddrres = rand128();
      mode_mask = 8'($urandom);
   endtask

   task automatic fillUniform(input logic [63:0] fill);
      for (int m = 0; m < 8; m++) begin
         cur_blk[m] = {16{fill[8*m +: 8]}};
      end
   endtask

   // Reference: plain integer SAD per mode, then pick the smallest among enabled modes.
   task automatic computeModel(input logic [7:0] mask);
      int sad [8];
      int best_m;
      logic signed [7:0] b;
      best_m = -1;
      for (int m = 0; m < 8; m++) begin
         sad[m] = 0;
         for (int s = 0; s < 16; s++) begin
            b = cur_blk[m][8*s +: 8];
            sad[m] += (b < 0) ? -int'(b) : int'(b);
         end
      end
      for (int m = 0; m < 8; m++) begin
         if (mask[m] && (best_m < 0 || sad[m] < sad[best_m])) best_m = m;
      end
      if (best_m < 0) begin
         exp_mode = 3'd0;
         exp_sad  = 12'hFFF;
         exp_none = 1'b1;
      end else begin
         exp_mode = 3'(best_m);
         exp_sad  = 12'(sad[best_m]);
         exp_none = 1'b0;
      end
   endtask

   // Launches one decision from cur_blk and checks busy, latency, result and pulse width.
   task automatic applyStimulus(input string tag, input logic [7:0] mask, input bit poke_in_eval);
      int n;
      logic [2:0] held_mode;
      driveBlocks();
      mode_mask = mask;
      start = 1'b1;
      tick();
      start = 1'b0;
      scramblePorts();
      checkOutput({tag, " busy_after_capture"}, 32'(busy), 32'd1);
      n = 0;
      while (!done && n < 20) begin
         tick();
         n++;
         if (poke_in_eval && n == 3) begin
            start = 1'b1;
            scramblePorts();
         end else if (poke_in_eval && n == 4) begin
            start = 1'b0;
         end
         if (n == 8 && !done) checkOutput({tag, " busy_late"}, 32'(busy), 32'd1);
      end
      checkOutput({tag, " latency"}, 32'(n), 32'd9);
      checkOutput({tag, " busy_at_done"}, 32'(busy), 32'd0);
      checkOutput({tag, " best_mode"}, 32'(best_mode), 32'(exp_mode));
      checkOutput({tag, " best_sad"}, 32'(best_sad), 32'(exp_sad));
      checkOutput({tag, " none_valid"}, 32'(none_valid), 32'(exp_none));
      held_mode = best_mode;
      tick();
      checkOutput({tag, " done_pulse"}, 32'(done), 32'd0);
      checkOutput({tag, " mode_hold"}, 32'(best_mode), 32'(held_mode));
   endtask

   initial begin
      vecs[0] = '{"zeros_tie",  8'hFF, 64'h0000_0000_0000_0000, 3'd0, 12'd0,    1'b0};
      vecs[1] = '{"hd_wins",    8'hFF, 64'h1010_0110_1010_1010, 3'd5, 12'd16,   1'b0};
      vecs[2] = '{"vl_wins",    8'hFF, 64'h7F80_7F7F_7FFF_7F7F, 3'd2, 12'd16,   1'b0};
      vecs[3] = '{"ddl_only",   8'h40, 64'h7F80_7F7F_7FFF_7F7F, 3'd6, 12'd2048, 1'b0};
      vecs[4] = '{"no_mode",    8'h00, 64'h1111_2222_3333_4444, 3'd0, 12'hFFF,  1'b1};
      vecs[5] = '{"tie_h_vr",   8'h0A, 64'h1010_1010_1010_1010, 3'd1, 12'd256,  1'b0};
      vecs[6] = '{"ddr_last",   8'hFF, 64'h0010_1010_1010_1010, 3'd7, 12'd0,    1'b0};
      vecs[7] = '{"ddr_neg",    8'h80, 64'hF0F0_F0F0_F0F0_F0F0, 3'd7, 12'd256,  1'b0};

      start = 1'b0;
      mode_mask = 8'h00;
      fillUniform(64'h0);
      driveBlocks();

      // Reset held with start asserted: nothing may start.
      reset = 1'b0;
      start = 1'b1;
      mode_mask = 8'hFF;
      tick();
      tick();
      tick();
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset best_mode", 32'(best_mode), 32'd0);
      checkOutput("reset best_sad", 32'(best_sad), 32'd0);
      checkOutput("reset none_valid", 32'(none_valid), 32'd0);
      start = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      checkOutput("post_reset busy", 32'(busy), 32'd0);

      for (int i = 0; i < 8; i++) begin
         fillUniform(vecs[i].fill);
         exp_mode = vecs[i].mode;
         exp_sad  = vecs[i].sad;
         exp_none = vecs[i].none;
         applyStimulus(vecs[i].name, vecs[i].mask, 1'b0);
      end

      // Start re-asserted during EVAL with new port data must be ignored.
      fillUniform(64'h1010_0110_1010_1010);
      exp_mode = 3'd5;
      exp_sad  = 12'd16;
      exp_none = 1'b0;
      applyStimulus("start_in_eval", 8'hFF, 1'b1);

      // Reset mid-EVAL aborts the decision and clears outputs.
      begin
         int seen;
         fillUniform(64'h0000_0000_0000_0000);
         driveBlocks();
         mode_mask = 8'hFF;
         start = 1'b1;
         tick();
         start = 1'b0;
         tick();
         tick();
         tick();
         reset = 1'b0;
         #1;
         checkOutput("abort busy", 32'(busy), 32'd0);
         checkOutput("abort done", 32'(done), 32'd0);
         checkOutput("abort best_mode", 32'(best_mode), 32'd0);
         checkOutput("abort best_sad", 32'(best_sad), 32'd0);
         checkOutput("abort none_valid", 32'(none_valid), 32'd0);
         tick();
         reset = 1'b1;
         seen = 0;
         for (int k = 0; k < 12; k++) begin
            tick();
            if (done) seen++;
         end
         checkOutput("abort no_done", 32'(seen), 32'd0);
         checkOutput("abort idle_busy", 32'(busy), 32'd0);
      end

      fillUniform(64'h7F80_7F7F_7FFF_7F7F);
      exp_mode = 3'd2;
      exp_sad  = 12'd16;
      exp_none = 1'b0;
      applyStimulus("after_abort", 8'hFF, 1'b0);

      // Randomized decisions, some with duplicated blocks to exercise ties.
      for (int r = 0; r < 24; r++) begin
         logic [7:0] m;
         for (int k = 0; k < 8; k++) begin
            cur_blk[k] = rand128();
         end
         if (r % 3 == 1) cur_blk[(r + 3) % 8] = cur_blk[r % 8];
         if (r % 5 == 2) begin
            for (int k = 0; k < 8; k++) cur_blk[k] = cur_blk[k] & {16{8'h83}};
         end
         if (r % 6 == 0)      m = 8'hFF;
         else if (r % 6 == 5) m = 8'h00;
         else                 m = 8'($urandom);
         computeModel(m);
         applyStimulus("random", m, (r % 4 == 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
